// File: rtl/ptp_ts_queue.sv
// ptp_ts_queue: pairs SOP-latched RTC timestamps with parser PTP results and queues them for readout
module ptp_ts_queue #(
  parameter int TS_WIDTH   = 80,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     int_valid,
  input  logic                     int_sop,
  input  logic [TS_WIDTH-1:0]      rtc_time,
  input  logic                     ptp_found,
  input  logic [31:0]              ptp_infor,
  input  logic                     q_clear,
  input  logic                     q_ready,
  output logic                     q_valid,
  output logic [31+TS_WIDTH:0]     q_data,
  output logic [DEPTH_LOG2:0]      q_level,
  output logic [15:0]              q_drop_cnt
);
  localparam int A  = DEPTH_LOG2;
  localparam int AW = DEPTH_LOG2 + 1;
  localparam int W  = 32 + TS_WIDTH;
  logic [W-1:0] mem [2**A];
  logic [TS_WIDTH-1:0] ts_sop;
  logic armed, found_d;
  logic [A:0] wr_ptr, rd_ptr, level_n;
  logic sop, push, pop, full, wr, drop;
  assign sop     = int_valid && int_sop;
  assign push    = ptp_found && !found_d && armed;
  assign pop     = q_valid && q_ready;
  assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {A{1'b0}}};
  // a pop frees the slot in the same cycle, so a full queue still accepts the push
  assign wr      = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign level_n = q_level + AW'(wr) - AW'(pop);
  assign q_data  = q_valid ? mem[rd_ptr[A-1:0]] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_sop     <= '0;
      armed      <= 1'b0;
      found_d    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_level    <= '0;
      q_valid    <= 1'b0;
      q_drop_cnt <= '0;
    end else begin
      found_d <= ptp_found;
      if (sop) ts_sop <= rtc_time;
      armed <= sop || (armed && !push);
      if (q_clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        q_level    <= '0;
        q_valid    <= 1'b0;
        q_drop_cnt <= '0;
      end else begin
        wr_ptr  <= wr_ptr + AW'(wr);
        rd_ptr  <= rd_ptr + AW'(pop);
        q_level <= level_n;
        q_valid <= level_n != '0;
        if (drop && q_drop_cnt != 16'hFFFF) q_drop_cnt <= q_drop_cnt + 16'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !q_clear) mem[wr_ptr[A-1:0]] <= {ptp_infor, ts_sop};
  end
endmodule

// File: tb/tb_ptp_ts_queue.sv
// tb_ptp_ts_queue: directed checks of timestamp capture, matching, overflow, clear and reset
module tb_ptp_ts_queue;
  logic clk = 0, rst_n = 0, int_valid = 0, int_sop = 0, ptp_found = 0, q_clear = 0, q_ready = 0;
  logic [79:0] rtc_time = '0;
  logic [31:0] ptp_infor = '0;
  logic q_valid;
  logic [111:0] q_data;
  logic [4:0] q_level;
  logic [15:0] q_drop_cnt;
  int tests = 0, fails = 0;

  ptp_ts_queue dut (
    .clk(clk), .rst_n(rst_n), .int_valid(int_valid), .int_sop(int_sop), .rtc_time(rtc_time),
    .ptp_found(ptp_found), .ptp_infor(ptp_infor), .q_clear(q_clear), .q_ready(q_ready),
    .q_valid(q_valid), .q_data(q_data), .q_level(q_level), .q_drop_cnt(q_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sop_at(input logic [79:0] ts);
    int_valid = 1; int_sop = 1; rtc_time = ts;
    tick();
    int_sop = 0; rtc_time = ts + 80'd7;
  endtask

  task automatic found(input logic [31:0] inf);
    ptp_infor = inf; ptp_found = 1;
    tick();
    ptp_found = 0;
  endtask

  task automatic pop1();
    q_ready = 1;
    tick();
    q_ready = 0;
  endtask

  initial begin
    tick(2);
    chk("rst_valid", q_valid, 0);
    chk("rst_level", q_level, 0);
    chk("rst_data", q_data, 0);
    chk("rst_drop", q_drop_cnt, 0);
    rst_n = 1;
    tick();
    // 1: L2 Sync, then 3: found held high
    sop_at(80'h1_0000_0064);
    tick(10);
    ptp_infor = 32'h0123_0042; ptp_found = 1;
    tick();
    chk("t1_valid", q_valid, 1);
    chk("t1_data", q_data, {32'h0123_0042, 80'h1_0000_0064});
    chk("t1_level", q_level, 1);
    tick(50);
    chk("t3_level", q_level, 1);
    ptp_found = 0;
    pop1();
    chk("t3_popped", q_level, 0);
    // 2: A's found coincides with B's SOP
    sop_at(80'd150);
    tick(3);
    ptp_infor = 32'hAAAA_0001; ptp_found = 1; int_sop = 1; rtc_time = 80'd200;
    tick();
    ptp_found = 0; int_sop = 0; rtc_time = 80'd999;
    tick(3);
    found(32'hBBBB_0002);
    chk("t2_level", q_level, 2);
    chk("t2_headA", q_data, {32'hAAAA_0001, 80'd150});
    pop1();
    chk("t2_headB", q_data, {32'hBBBB_0002, 80'd200});
    pop1();
    chk("t2_empty", q_valid, 0);
    // 4: overflow
    for (int i = 1; i <= 20; i++) begin
      sop_at(80'd1000 + 80'(i));
      tick();
      found(32'(i));
    end
    chk("t4_level", q_level, 16);
    chk("t4_drop", q_drop_cnt, 4);
    chk("t4_head", q_data, {32'd1, 80'd1001});
    sop_at(80'd1021);
    tick();
    ptp_infor = 32'd21; ptp_found = 1; q_ready = 1;
    tick();
    ptp_found = 0; q_ready = 0;
    chk("t4_pp_level", q_level, 16);
    chk("t4_pp_drop", q_drop_cnt, 4);
    chk("t4_pp_head", q_data, {32'd2, 80'd1002});
    // 5: drain and clear
    for (int i = 2; i <= 4; i++) begin
      chk("t5_order", q_data, {32'(i), 80'd1000 + 80'(i)});
      pop1();
    end
    chk("t5_level", q_level, 13);
    chk("t5_head", q_data, {32'd5, 80'd1005});
    q_clear = 1;
    tick();
    q_clear = 0;
    chk("t5_clr_level", q_level, 0);
    chk("t5_clr_valid", q_valid, 0);
    chk("t5_clr_data", q_data, 0);
    chk("t5_clr_drop", q_drop_cnt, 0);
    pop1();
    chk("t5_emptypop_level", q_level, 0);
    chk("t5_emptypop_valid", q_valid, 0);
    // 6: reset mid-packet
    sop_at(80'd3000);
    tick();
    found(32'hCCCC_0003);
    chk("t6_pre_level", q_level, 1);
    sop_at(80'd5000);
    tick(2);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_valid", q_valid, 0);
    chk("t6_rst_level", q_level, 0);
    chk("t6_rst_data", q_data, 0);
    tick();
    rst_n = 1;
    tick();
    found(32'hDDDD_0004);
    tick(3);
    chk("t6_norecord_level", q_level, 0);
    chk("t6_norecord_valid", q_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
